// File: rtl/tff_updn_counter_cell.sv
// Toggle flip-flop cell used as the state bit of the counter.
// Asynchronous active-high reset clears the bit.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qb
);

  logic state_q;

  // Toggle the stored bit on every edge where t is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= 1'b0;
    end else if (t) begin
      state_q <= ~state_q;
    end
  end

  assign q  = state_q;
  assign qb = ~state_q;

endmodule

// File: rtl/tff_updn_counter.sv
// Up/down counter built from toggle cells, with parallel load,
// clamp to MAXVAL, wrap or saturate at the limits, tc and ovf.
module tff_updn_counter #(
  parameter int WIDTH    = 4,
  parameter int MAXVAL   = 2**WIDTH-1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $fatal(1, "tff_updn_counter: WIDTH must be 1..16");
  end

  if (MAXVAL < 1 || MAXVAL > (2**WIDTH)-1) begin : g_bad_max
    $fatal(1, "tff_updn_counter: MAXVAL must be 1..2**WIDTH-1");
  end

  if (SATURATE != 0 && SATURATE != 1) begin : g_bad_sat
    $fatal(1, "tff_updn_counter: SATURATE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAXVAL);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);
  localparam bit               SAT   = (SATURATE != 0);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] qb_w;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] t_w;
  logic [WIDTH-1:0] d_clamp;
  logic             ovf_d;
  logic             ovf_q;
  logic             at_max;
  logic             at_zero;
  logic             over_max;
  logic             d_big;

  // With a full-range MAXVAL no value can exceed it, so skip the compare
  if (MAXVAL == (2**WIDTH)-1) begin : g_full
    assign over_max = 1'b0;
    assign d_big    = 1'b0;
  end else begin : g_part
    assign over_max = (q_q > MAX_V);
    assign d_big    = (d > MAX_V);
  end

  assign at_max  = (q_q == MAX_V);
  assign at_zero = (q_q == '0);
  assign d_clamp = d_big ? MAX_V : d;

  // Next count value and wrap detection
  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    if (load) begin
      q_d = d_clamp;
    end else if (en) begin
      if (up) begin
        if (over_max) begin
          q_d = '0;
        end else if (at_max) begin
          if (!SAT) begin
            q_d   = '0;
            ovf_d = 1'b1;
          end
        end else begin
          q_d = q_q + ONE_V;
        end
      end else begin
        if (over_max) begin
          q_d = MAX_V;
        end else if (at_zero) begin
          if (!SAT) begin
            q_d   = MAX_V;
            ovf_d = 1'b1;
          end
        end else begin
          q_d = q_q - ONE_V;
        end
      end
    end
  end

  // Each bit toggles exactly when its next value differs
  assign t_w = q_q ^ q_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t_w[i]),
      .q   (q_q[i]),
      .qb  (qb_w[i])
    );
  end

  // One-cycle wrap pulse, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign tc  = en & ~load & ((up & at_max) | (~up & at_zero));
  assign q   = q_q;
  assign qb  = qb_w;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_tff_updn_counter.sv
// Scoreboard bench for tff_updn_counter across three parameter sets.
// Driver queues expected post-edge state; a monitor checks it.
module tb_tff_updn_counter;

  typedef struct {
    int         u;
    logic [3:0] q;
    logic       ovf;
    string      nm;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst;

  logic       en_a, up_a, ld_a;
  logic [3:0] d_a, q_a, qb_a;
  logic       tc_a, ovf_a;

  logic       en_b, up_b, ld_b;
  logic [3:0] d_b, q_b, qb_b;
  logic       tc_b, ovf_b;

  logic       en_c, up_c, ld_c;
  logic [0:0] d_c, q_c, qb_c;
  logic       tc_c, ovf_c;

  always #5 clk = ~clk;

  tff_updn_counter #(.WIDTH(4), .MAXVAL(9), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .up(up_a), .load(ld_a),
    .d(d_a), .q(q_a), .qb(qb_a), .tc(tc_a), .ovf(ovf_a)
  );

  tff_updn_counter #(.WIDTH(4), .MAXVAL(9), .SATURATE(1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .up(up_b), .load(ld_b),
    .d(d_b), .q(q_b), .qb(qb_b), .tc(tc_b), .ovf(ovf_b)
  );

  tff_updn_counter #(.WIDTH(1), .MAXVAL(1), .SATURATE(0)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .up(up_c), .load(ld_c),
    .d(d_c), .q(q_c), .qb(qb_c), .tc(tc_c), .ovf(ovf_c)
  );

  task automatic check(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_all();
    en_a = 1'b0; ld_a = 1'b0;
    en_b = 1'b0; ld_b = 1'b0;
    en_c = 1'b0; ld_c = 1'b0;
  endtask

  task automatic step(input int u, input logic e, input logic dir,
                      input logic ld, input logic [3:0] dv,
                      input logic [3:0] eq, input logic eo,
                      input logic et, input string nm);
    exp_t x;
    @(negedge clk);
    idle_all();
    case (u)
      0: begin en_a = e; up_a = dir; ld_a = ld; d_a = dv; end
      1: begin en_b = e; up_b = dir; ld_b = ld; d_b = dv; end
      default: begin
        en_c = e; up_c = dir; ld_c = ld; d_c = dv[0];
      end
    endcase
    #1;
    case (u)
      0: check({nm, " tc"}, {3'b0, tc_a}, {3'b0, et});
      1: check({nm, " tc"}, {3'b0, tc_b}, {3'b0, et});
      default: check({nm, " tc"}, {3'b0, tc_c}, {3'b0, et});
    endcase
    x.u = u; x.q = eq; x.ovf = eo; x.nm = nm;
    sb.push_back(x);
  endtask

  // Monitor: compare queued expectations just after each rising edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        x = sb.pop_front();
        case (x.u)
          0: begin
            check({x.nm, " q"}, q_a, x.q);
            check({x.nm, " qb"}, qb_a, ~x.q);
            check({x.nm, " ovf"}, {3'b0, ovf_a}, {3'b0, x.ovf});
          end
          1: begin
            check({x.nm, " q"}, q_b, x.q);
            check({x.nm, " qb"}, qb_b, ~x.q);
            check({x.nm, " ovf"}, {3'b0, ovf_b}, {3'b0, x.ovf});
          end
          default: begin
            check({x.nm, " q"}, {3'b0, q_c}, x.q);
            check({x.nm, " qb"}, {3'b0, qb_c}, {3'b0, ~x.q[0]});
            check({x.nm, " ovf"}, {3'b0, ovf_c}, {3'b0, x.ovf});
          end
        endcase
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_all();
    up_a = 1'b1; up_b = 1'b1; up_c = 1'b1;
    d_a = '0; d_b = '0; d_c = '0;
    #1;
    check("rst q_a", q_a, 4'h0);
    check("rst qb_a", qb_a, 4'hF);
    check("rst ovf_a", {3'b0, ovf_a}, 4'h0);
    check("rst q_b", q_b, 4'h0);
    check("rst qb_c", {3'b0, qb_c}, 4'h1);
    @(negedge clk);
    rst = 1'b0;

    // Wrap-mode up count through 9 -> 0
    for (int k = 1; k <= 12; k++)
      step(0, 1'b1, 1'b1, 1'b0, 4'h0, 4'(k % 10),
           k == 10, k == 10, "a up");

    // Wrap-mode down count through 0 -> 9
    step(0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, "a ld0");
    step(0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h9, 1'b1, 1'b1, "a dn wrap");
    step(0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0, "a dn");

    // Load clamp, load beats enable, hold
    step(0, 1'b0, 1'b0, 1'b1, 4'hF, 4'h9, 1'b0, 1'b0, "a clamp");
    step(0, 1'b1, 1'b1, 1'b1, 4'h3, 4'h3, 1'b0, 1'b0, "a ld+en");
    step(0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h3, 1'b0, 1'b0, "a hold");

    // Saturating counter
    step(1, 1'b0, 1'b1, 1'b1, 4'h8, 4'h8, 1'b0, 1'b0, "b ld8");
    for (int k = 1; k <= 3; k++)
      step(1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h9, 1'b0, k >= 2, "b up");
    for (int k = 1; k <= 11; k++)
      step(1, 1'b1, 1'b0, 1'b0, 4'h0,
           (k <= 9) ? 4'(9 - k) : 4'h0, 1'b0, k >= 10, "b dn");

    // One-bit counter acts as a plain T flip-flop
    for (int k = 1; k <= 6; k++)
      step(2, 1'b1, 1'b1, 1'b0, 4'h0, 4'(k % 2),
           (k % 2) == 0, (k % 2) == 0, "c tff");

    // Reset asserted between edges while counting from 5
    step(0, 1'b0, 1'b0, 1'b1, 4'h5, 4'h5, 1'b0, 1'b0, "a ld5");
    @(negedge clk);
    idle_all();
    en_a = 1'b1; up_a = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("mid rst q", q_a, 4'h0);
    check("mid rst qb", qb_a, 4'hF);
    check("mid rst ovf", {3'b0, ovf_a}, 4'h0);
    @(posedge clk);
    #1;
    check("held rst q", q_a, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    en_a = 1'b0;
    step(0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, "a resume");
    step(0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h2, 1'b0, 1'b0, "a resume");

    // Reset while an ovf pulse is showing leaves no residue
    step(0, 1'b0, 1'b0, 1'b1, 4'h9, 4'h9, 1'b0, 1'b0, "a ld9");
    step(0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, "a wrap");
    @(negedge clk);
    idle_all();
    rst = 1'b1;
    #1;
    check("rst ovf kill", {3'b0, ovf_a}, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "a post rst");

    @(negedge clk);
    idle_all();
    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
